// File: rtl/dn_loader_pkg.sv
// dn_loader_pkg: shared types and constants for the download sequencer.
package dn_loader_pkg;

  // Sequencer states; anything other than ST_IDLE holds the system in reset.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RELEASE = 2'd3
  } dl_state_e;

  // Width of the ioctl byte address bus.
  localparam int IOCTL_ADDR_W = 25;

  // A buffered write is {index, addr, data}.
  function automatic int entry_width(input int addr_w);
    return 8 + addr_w + 8;
  endfunction

endpackage

// File: rtl/dn_loader_fifo.sv
// dn_loader_fifo: synchronous FIFO with a combinational head read.
// A push while full is taken only when a pop frees the head slot in the same cycle.
module dn_loader_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Storage array; no reset so it maps onto RAM resources.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/dn_loader.sv
// dn_loader: buffers ioctl download bytes onto the dn_* write port, range-checks
// addresses and holds the system in reset for the download plus a release tail.
// Optional DN_LOADER_CHECKSUM_EN adds a modulo-256 checksum of issued bytes.
module dn_loader
  import dn_loader_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int FIFO_DEPTH     = 4,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  input  logic [7:0]              ioctl_index,
  output logic                    ioctl_wait,
  output logic [ADDR_W-1:0]       dn_addr,
  output logic [7:0]              dn_data,
  output logic [7:0]              dn_index,
  output logic                    dn_wr,
  input  logic                    dn_ready,
  output logic                    sys_reset,
  output logic                    dl_active,
  output logic                    dl_error,
  output logic [IOCTL_ADDR_W-1:0] byte_count
`ifdef DN_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]              checksum
`endif
);

  localparam int ENTRY_W = entry_width(ADDR_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int REL_W   = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  dl_state_e               state_q, state_d;
  logic                    dl_prev_q;
  logic [REL_W-1:0]        rel_cnt_q, rel_cnt_d;
  logic [IOCTL_ADDR_W-1:0] byte_count_q, byte_count_d;
  logic                    dl_error_q, dl_error_d;
  logic                    wait_q, wait_d;
  logic                    dn_wr_q, dn_wr_d;
  logic [ADDR_W-1:0]       dn_addr_q, dn_addr_d;
  logic [7:0]              dn_data_q, dn_data_d;
  logic [7:0]              dn_index_q, dn_index_d;

  logic                    dl_rise;
  logic                    in_range;
  logic                    accept;
  logic                    drop;
  logic                    pop;
  logic [CNT_W-1:0]        count_next;
  logic [ENTRY_W-1:0]      fifo_din;
  logic [ENTRY_W-1:0]      fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;

  dn_loader_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (accept),
    .pop     (pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Accept/drop decision, FSM next state, counters and the issue path.
  always_comb begin
    dl_rise  = ioctl_download && !dl_prev_q;
    in_range = (ioctl_addr[IOCTL_ADDR_W-1:ADDR_W] == '0);
    pop      = !fifo_empty && dn_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    accept   = (state_q == ST_ACTIVE) && ioctl_wr && in_range && (!fifo_full || pop);
    drop     = (state_q == ST_ACTIVE) && ioctl_wr && !accept;
    fifo_din = {ioctl_index, ioctl_addr[ADDR_W-1:0], ioctl_dout};
    count_next = fifo_count + CNT_W'(accept) - CNT_W'(pop);

    state_d      = state_q;
    rel_cnt_d    = rel_cnt_q;
    byte_count_d = byte_count_q + IOCTL_ADDR_W'(accept);
    dl_error_d   = dl_error_q || drop;

    case (state_q)
      ST_IDLE: begin
        if (dl_rise) begin
          state_d      = ST_ACTIVE;
          byte_count_d = '0;
          dl_error_d   = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (!ioctl_download) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dl_rise) begin
          state_d      = ST_ACTIVE;
          byte_count_d = '0;
          dl_error_d   = 1'b0;
        end else if (fifo_empty) begin
          // The last issued write is already on the port and ends at this edge.
          state_d   = ST_RELEASE;
          rel_cnt_d = REL_W'(RELEASE_CYCLES - 1);
        end
      end
      default: begin
        if (dl_rise) begin
          state_d      = ST_ACTIVE;
          byte_count_d = '0;
          dl_error_d   = 1'b0;
        end else if (rel_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q - REL_W'(1);
        end
      end
    endcase

    // One entry of slack covers a write already in flight from the source.
    wait_d = (state_d == ST_ACTIVE) && (count_next >= CNT_W'(FIFO_DEPTH - 1));

    dn_wr_d    = pop;
    dn_addr_d  = dn_addr_q;
    dn_data_d  = dn_data_q;
    dn_index_d = dn_index_q;
    if (pop) begin
      dn_index_d = fifo_dout[ENTRY_W-1 -: 8];
      dn_addr_d  = fifo_dout[ADDR_W+7:8];
      dn_data_d  = fifo_dout[7:0];
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dl_prev_q    <= 1'b0;
      rel_cnt_q    <= '0;
      byte_count_q <= '0;
      dl_error_q   <= 1'b0;
      wait_q       <= 1'b0;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_index_q   <= '0;
    end else begin
      state_q      <= state_d;
      dl_prev_q    <= ioctl_download;
      rel_cnt_q    <= rel_cnt_d;
      byte_count_q <= byte_count_d;
      dl_error_q   <= dl_error_d;
      wait_q       <= wait_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_index_q   <= dn_index_d;
    end
  end

`ifdef DN_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  // Running sum of issued bytes; restarts only on a fresh download from idle.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == ST_IDLE && dl_rise) checksum_d = '0;
    else if (pop)                      checksum_d = checksum_q + fifo_dout[7:0];
  end

  // Checksum register.
  always_ff @(posedge clk_sys) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  assign ioctl_wait = wait_q;
  assign dn_wr      = dn_wr_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_index   = dn_index_q;
  assign dl_error   = dl_error_q;
  assign byte_count = byte_count_q;
  assign dl_active  = (state_q != ST_IDLE);
  assign sys_reset  = reset || (state_q != ST_IDLE);

endmodule

// File: doc/dn_loader.md
Name: dn_loader

Overview:
- Download sequencer between the ioctl byte stream and the system's `dn_*` write port.
- Buffers ioctl writes in a small FIFO and applies backpressure via `ioctl_wait` when the target stalls.
- Range-checks addresses against the system address width.
- Holds the system in reset for the whole download plus a fixed release tail, then releases it.

Parameters:
- ADDR_W, 14, width of `dn_addr`; ioctl addresses at or above 2^ADDR_W are out of range.
- FIFO_DEPTH, 4, write buffer entries; power of 2, minimum 2.
- RELEASE_CYCLES, 16, clk_sys cycles that `sys_reset` stays high after the FIFO drains; minimum 1.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  byte write strobe, one cycle
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_index  in  8  download target index
- ioctl_wait  out  1  backpressure to the ioctl source
- dn_addr  out  ADDR_W  target write address
- dn_data  out  8  target write data
- dn_index  out  8  target index for this write
- dn_wr  out  1  target write strobe, one cycle
- dn_ready  in  1  target accepts a write this cycle
- sys_reset  out  1  reset to system core
- dl_active  out  1  high in any state except IDLE
- dl_error  out  1  sticky error flag, cleared at download start
- byte_count  out  25  number of bytes accepted into the FIFO

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE and the FIFO is flushed.
  - `dn_wr`, `ioctl_wait`, `dl_error`, `byte_count` and the release counter go to 0.
  - `dn_addr`, `dn_data` and `dn_index` go to 0.
  - `sys_reset` = reset OR (state != IDLE), so it is high during reset.
- States: IDLE, ACTIVE, DRAIN, RELEASE.
  - IDLE -> ACTIVE on the rising edge of `ioctl_download` (registered edge detect). On entry: clear `byte_count` and `dl_error`.
  - ACTIVE -> DRAIN when `ioctl_download` falls.
  - DRAIN -> RELEASE when the FIFO is empty and no `dn_wr` is outstanding. On entry: load the release counter with RELEASE_CYCLES-1.
  - RELEASE counts down to 0, then -> IDLE.
  - A rising edge of `ioctl_download` in DRAIN or RELEASE -> ACTIVE. The FIFO contents are kept; `byte_count` and `dl_error` are cleared.
- Accept rule: push {index, addr[ADDR_W-1:0], data} only when all of these hold:
  - state == ACTIVE;
  - `ioctl_wr` is high;
  - `ioctl_addr[24:ADDR_W]` == 0;
  - the FIFO is not full.
  - Each accepted write increments `byte_count` (width 25, wraps).
- Ignored writes:
  - `ioctl_wr` in IDLE, DRAIN or RELEASE is ignored, with no error.
  - An out-of-range address is dropped and sets `dl_error`.
  - A write while the FIFO is full (source ignored `ioctl_wait`) is dropped and sets `dl_error`.
- `ioctl_wait`:
  - Registered, high when FIFO occupancy after this cycle's push/pop is >= FIFO_DEPTH-1. This gives one entry of slack for a write in flight.
  - Always 0 outside ACTIVE.
- Pop/issue:
  - If the FIFO is non-empty and `dn_ready` is high, pop the head and register it onto `dn_addr`/`dn_data`/`dn_index` with `dn_wr`=1 for one cycle.
  - Otherwise `dn_wr`=0 and the data outputs hold their last values.
- Latency: a write accepted at edge N into an empty FIFO, with `dn_ready` high, shows `dn_wr` at edge N+1. Throughput is 1 byte/cycle.
- Push and pop in the same cycle: occupancy is unchanged. This is legal when full, since the pop frees the slot before the push (write-through-on-pop allowed).
- `dl_active` = (state != IDLE).

Optional Feature:
- Macro: DN_LOADER_CHECKSUM_EN.
- With the macro:
  - Extra output port `checksum` (out, 8): running modulo-256 sum of `dn_data` over every issued `dn_wr`.
  - Cleared on IDLE->ACTIVE and on reset; holds its value after the download.
- Without the macro: the port and adder are absent and behaviour is otherwise identical.

Decomposition:
- Package `dn_loader_pkg`:
  - state enum (IDLE/ACTIVE/DRAIN/RELEASE);
  - ioctl address width constant 25;
  - FIFO entry width function (8+ADDR_W+8).
- Sub-module `dn_loader_fifo`:
  - synchronous FIFO, parameters WIDTH and DEPTH;
  - ports push/pop/din/dout/full/empty/count;
  - flushes on reset.

Test Plan:
- Basic load: `dn_ready`=1; download 5 bytes, addr 0..4, data 0xA0..0xA4, index 0x01.
  - Required: 5 `dn_wr` pulses, each 1 cycle after its `ioctl_wr`; `byte_count`=5.
  - Required: `sys_reset` falls exactly 16 cycles after the last `dn_wr` completes the drain.
- Backpressure: `dn_ready`=0; 4 writes back-to-back.
  - Required: `ioctl_wait` high after the 3rd write; the 4th is accepted; `dl_error`=0.
  - Then `dn_ready`=1: 4 `dn_wr` pulses in order.
- Overflow: `dn_ready`=0; 5 writes ignoring `ioctl_wait`.
  - Required: the 5th is dropped and `dl_error`=1; only 4 `dn_wr` pulses after `dn_ready`=1.
- Range: write to addr 0x4000 with ADDR_W=14.
  - Required: no `dn_wr`, `dl_error`=1, `byte_count` unchanged.
  - A new download start clears `dl_error` to 0.
- Re-entry and reset:
  - Re-raise `ioctl_download` during RELEASE -> ACTIVE; `sys_reset` stays high continuously.
  - Assert `reset` mid-ACTIVE with 2 entries buffered -> next cycle: IDLE, no further `dn_wr`, `byte_count`=0.
- Checksum (macro on): bytes 0xFF, 0x02, 0x10 -> `checksum`=0x11.
